// File: rtl/toggle_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : toggle_window_sequencer
// Description : Generates a toggling control line for a programmed number of
//               transitions after a start request. It also provides a busy
//               window, a running toggle count and a one-cycle done pulse.
//
//   Ports
//     clk      in   1       clock, all state changes on posedge
//     rst      in   1       asynchronous active-low reset
//     start    in   1       run request, sampled only while idle
//     len      in   CNT_W   toggles requested (clamped to MAX_LEN)
//     hold_m1  in   HOLD_W  level hold length minus one
//     abort    in   1       synchronous cancel of an active run
//     tog_out  out  1       generated toggling signal
//     busy     out  1       high while a run is active (LEAD or RUN)
//     count    out  CNT_W   toggles issued in the current or last run
//     done     out  1       one-cycle pulse at normal completion
//
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_window_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1),
  parameter int HOLD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [HOLD_W-1:0] hold_m1,
  input  logic              abort,
  output logic              tog_out,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LEAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] C_MAX_LEN = CNT_W'(MAX_LEN);

  logic [1:0]        state_q, state_d;
  logic              tog_q, tog_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [HOLD_W-1:0] hm1_q, hm1_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [CNT_W-1:0]  len_eff;

  assign len_eff = (len > C_MAX_LEN) ? C_MAX_LEN : len;

  always_comb begin
    state_d = state_q;
    tog_d   = tog_q;
    count_d = count_q;
    len_d   = len_q;
    hm1_d   = hm1_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE: begin
        // start has priority over abort here; abort is meaningless when idle
        if (start) begin
          count_d = '0;
          if (len_eff != '0) begin
            len_d   = len_eff;
            hm1_d   = hold_m1;
            state_d = S_LEAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_LEAD: begin
        if (abort) begin
          state_d = S_IDLE;
          tog_d   = 1'b0;
        end else begin
          // First toggle is issued on the transition into RUN
          state_d = S_RUN;
          tog_d   = ~tog_q;
          count_d = count_q + 1'b1;
          hold_d  = hm1_q;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          tog_d   = 1'b0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (count_q < len_q) begin
          tog_d   = ~tog_q;
          count_d = count_q + 1'b1;
          hold_d  = hm1_q;
        end else begin
          // Final level has been held its full length; tog_out keeps it
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so that they line up
  // with the state they describe without any input-to-output path.
  always_comb begin
    busy_d = (state_d == S_LEAD) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tog_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      hm1_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      tog_q   <= tog_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      len_q   <= len_d;
      hm1_q   <= hm1_d;
      hold_q  <= hold_d;
    end
  end

  assign tog_out = tog_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_window_sequencer
// Description : Self-checking bench for toggle_window_sequencer. Expected
//               per-cycle outputs are queued when a run is launched and
//               compared, one entry per cycle, on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_window_sequencer;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;
  localparam int HOLD_W  = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [HOLD_W-1:0] hold_m1;
  logic              abort;
  logic              tog_out;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              done;

  typedef struct packed {
    logic             tog;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_tog  = 1'b0;

  toggle_window_sequencer #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W),
    .HOLD_W  (HOLD_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .hold_m1 (hold_m1),
    .abort   (abort),
    .tog_out (tog_out),
    .busy    (busy),
    .count   (count),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Queue the expected trace of one accepted start, beginning with the
  // cycle right after the start edge and ending with one idle cycle.
  task automatic push_run(input int req_len, input int hold);
    int le;
    le = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    if (le == 0) begin
      exp_q.push_back('{exp_tog, 1'b0, CNT_W'(0), 1'b1});
      exp_q.push_back('{exp_tog, 1'b0, CNT_W'(0), 1'b0});
      return;
    end
    exp_q.push_back('{exp_tog, 1'b1, CNT_W'(0), 1'b0});
    for (int k = 1; k <= le; k++) begin
      exp_tog = ~exp_tog;
      for (int h = 0; h <= hold; h++)
        exp_q.push_back('{exp_tog, 1'b1, CNT_W'(k), 1'b0});
    end
    exp_q.push_back('{exp_tog, 1'b0, CNT_W'(le), 1'b1});
    exp_q.push_back('{exp_tog, 1'b0, CNT_W'(le), 1'b0});
  endtask

  // Drive a start on the next rising edge.
  task automatic launch(input int req_len, input int hold);
    @(negedge clk);
    start   = 1'b1;
    len     = CNT_W'(req_len);
    hold_m1 = HOLD_W'(hold);
    @(posedge clk);
  endtask

  // Pop and compare one entry per cycle; optionally pulse start or abort
  // during the cycle of a given entry index.
  task automatic drain(input string name, input int start_idx, input int abort_idx);
    exp_t e;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = (i == start_idx);
      abort = (i == abort_idx);
      if (i == start_idx) begin
        len     = CNT_W'(2);
        hold_m1 = HOLD_W'(0);
      end
      e = exp_q.pop_front();
      check_eq({name, ".tog"},   int'(tog_out), int'(e.tog));
      check_eq({name, ".busy"},  int'(busy),    int'(e.busy));
      check_eq({name, ".count"}, int'(count),   int'(e.cnt));
      check_eq({name, ".done"},  int'(done),    int'(e.done));
      i++;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    len     = '0;
    hold_m1 = '0;
    abort   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.tog",   int'(tog_out), 0);
    check_eq("reset.busy",  int'(busy),    0);
    check_eq("reset.count", int'(count),   0);
    check_eq("reset.done",  int'(done),    0);
    rst = 1'b1;
    @(negedge clk);

    // len=7, hold 0, with an ignored start pulse while busy
    launch(7, 0);
    push_run(7, 0);
    drain("len7", 3, -1);

    // len=3, each level held 3 cycles
    launch(3, 2);
    push_run(3, 2);
    drain("len3h2", -1, -1);

    // len=0: immediate done, tog_out unchanged
    launch(0, 0);
    push_run(0, 0);
    drain("len0", -1, -1);

    // len above MAX_LEN clamps to 16 toggles
    launch(20, 1);
    push_run(20, 1);
    drain("len20", -1, -1);

    // abort two cycles into a len=10 run
    launch(10, 0);
    exp_q.push_back('{exp_tog, 1'b1, CNT_W'(0), 1'b0});
    exp_q.push_back('{~exp_tog, 1'b1, CNT_W'(1), 1'b0});
    exp_tog = 1'b0;
    exp_q.push_back('{1'b0, 1'b0, CNT_W'(1), 1'b0});
    exp_q.push_back('{1'b0, 1'b0, CNT_W'(1), 1'b0});
    drain("abort", -1, 1);

    // asynchronous reset mid-run, checked between clock edges
    launch(7, 2);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_eq("midrst.pre_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_eq("midrst.tog",   int'(tog_out), 0);
    check_eq("midrst.busy",  int'(busy),    0);
    check_eq("midrst.count", int'(count),   0);
    check_eq("midrst.done",  int'(done),    0);
    @(negedge clk);
    rst = 1'b1;
    exp_tog = 1'b0;

    launch(7, 0);
    push_run(7, 0);
    drain("post_rst", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
